// File: rtl/riscv_dm_icb_arb_if.sv
// ============================================================================
// Module   : riscv_dm_icb_arb_if
// Brief    : ICB command/response channel bundle (one master, one slave)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface riscv_dm_icb_arb_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_read;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

`default_nettype wire

// File: rtl/riscv_dm_icb_arb.sv
// ============================================================================
// Module   : riscv_dm_icb_arb
// Brief    : 2:1 round-robin ICB arbiter in front of the Debug Module bus port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_dm_icb_arb #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    riscv_dm_icb_arb_if.slave       m0_icb,
    riscv_dm_icb_arb_if.slave       m1_icb,
    riscv_dm_icb_arb_if.master      i_icb,
    output logic                    o_busy,
    output logic [1:0]              o_grant
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_grant;
    logic       r_rr_ptr;
    logic       r_busy;

    logic w_sel1;
    logic w_in_cmd;
    logic w_in_rsp;
    logic w_g_cmd_valid;
    logic w_g_rsp_ready;

    assign w_sel1        = r_grant[1];
    assign w_in_cmd      = (r_state == S_CMD);
    assign w_in_rsp      = (r_state == S_RSP);
    assign w_g_cmd_valid = w_sel1 ? m1_icb.cmd_valid : m0_icb.cmd_valid;
    assign w_g_rsp_ready = w_sel1 ? m1_icb.rsp_ready : m0_icb.rsp_ready;

    // Command path to the DM: live only in CMD, zero otherwise
    assign i_icb.cmd_valid = w_in_cmd & w_g_cmd_valid;
    assign i_icb.cmd_addr  = w_in_cmd ? (w_sel1 ? m1_icb.cmd_addr  : m0_icb.cmd_addr)  : '0;
    assign i_icb.cmd_read  = w_in_cmd & (w_sel1 ? m1_icb.cmd_read : m0_icb.cmd_read);
    assign i_icb.cmd_wdata = w_in_cmd ? (w_sel1 ? m1_icb.cmd_wdata : m0_icb.cmd_wdata) : '0;
    assign i_icb.rsp_ready = w_in_rsp & w_g_rsp_ready;

    assign m0_icb.cmd_ready = w_in_cmd & r_grant[0] & i_icb.cmd_ready;
    assign m1_icb.cmd_ready = w_in_cmd & r_grant[1] & i_icb.cmd_ready;
    assign m0_icb.rsp_valid = w_in_rsp & r_grant[0] & i_icb.rsp_valid;
    assign m1_icb.rsp_valid = w_in_rsp & r_grant[1] & i_icb.rsp_valid;
    assign m0_icb.rsp_rdata = (w_in_rsp & r_grant[0]) ? i_icb.rsp_rdata : '0;
    assign m1_icb.rsp_rdata = (w_in_rsp & r_grant[1]) ? i_icb.rsp_rdata : '0;

    assign o_busy  = r_busy;
    assign o_grant = r_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_grant  <= 2'b00;
            r_rr_ptr <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (m0_icb.cmd_valid | m1_icb.cmd_valid) begin
                        // Tie goes to rr_ptr; a lone requester wins outright
                        if (m0_icb.cmd_valid & m1_icb.cmd_valid)
                            r_grant <= r_rr_ptr ? 2'b10 : 2'b01;
                        else
                            r_grant <= m1_icb.cmd_valid ? 2'b10 : 2'b01;
                        r_state <= S_CMD;
                        r_busy  <= 1'b1;
                    end
                end
                S_CMD: begin
                    if (!w_g_cmd_valid) begin
                        r_state <= S_IDLE;
                        r_grant <= 2'b00;
                        r_busy  <= 1'b0;
                    end else if (i_icb.cmd_ready) begin
                        r_state <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (i_icb.rsp_valid & w_g_rsp_ready) begin
                        r_state  <= S_IDLE;
                        r_grant  <= 2'b00;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= r_grant[0];
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_riscv_dm_icb_arb.sv
// ============================================================================
// Module   : tb_riscv_dm_icb_arb
// Brief    : Directed self-checking bench for riscv_dm_icb_arb
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_dm_icb_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       o_busy;
    logic [1:0] o_grant;
    int         n_chk = 0;
    int         n_pass = 0;

    riscv_dm_icb_arb_if #(.AW(12), .DW(32)) m0 ();
    riscv_dm_icb_arb_if #(.AW(12), .DW(32)) m1 ();
    riscv_dm_icb_arb_if #(.AW(12), .DW(32)) dm ();

    riscv_dm_icb_arb #(.AW(12), .DW(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m0_icb  (m0),
        .m1_icb  (m1),
        .i_icb   (dm),
        .o_busy  (o_busy),
        .o_grant (o_grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string t);
        check({t, ".grant"},  o_grant,         64'd0);
        check({t, ".busy"},   o_busy,          64'd0);
        check({t, ".cvalid"}, dm.cmd_valid,    64'd0);
        check({t, ".m0rv"},   m0.rsp_valid,    64'd0);
        check({t, ".m1rv"},   m1.rsp_valid,    64'd0);
    endtask

    // One transaction with an immediately-ready DM; m1 address/data are
    // derived from m0's so routing errors show up as wrong values.
    task automatic txn(input string t, input logic v0, input logic v1, input logic win,
                       input logic [11:0] a, input logic rd, input logic [31:0] wd,
                       input logic [31:0] rdat);
        logic [11:0] wa;
        logic [31:0] wwd;
        wa  = win ? (a ^ 12'h100) : a;
        wwd = win ? ~wd : wd;
        tick();
        m0.cmd_valid = v0; m0.cmd_addr = a;            m0.cmd_read = rd; m0.cmd_wdata = wd;
        m1.cmd_valid = v1; m1.cmd_addr = a ^ 12'h100;  m1.cmd_read = rd; m1.cmd_wdata = ~wd;
        m0.rsp_ready = 1'b1; m1.rsp_ready = 1'b1;
        dm.cmd_ready = 1'b1; dm.rsp_valid = 1'b0;
        @(negedge clk);
        check({t, ".idle_grant"},  o_grant,      64'd0);
        check({t, ".idle_cvalid"}, dm.cmd_valid, 64'd0);
        tick();
        @(negedge clk);
        check({t, ".grant"},  o_grant,      win ? 64'd2 : 64'd1);
        check({t, ".busy"},   o_busy,       64'd1);
        check({t, ".cvalid"}, dm.cmd_valid, 64'd1);
        check({t, ".addr"},   dm.cmd_addr,  {52'd0, wa});
        check({t, ".read"},   dm.cmd_read,  {63'd0, rd});
        check({t, ".wdata"},  dm.cmd_wdata, {32'd0, wwd});
        check({t, ".win_crdy"},  win ? m1.cmd_ready : m0.cmd_ready, 64'd1);
        check({t, ".lose_crdy"}, win ? m0.cmd_ready : m1.cmd_ready, 64'd0);
        tick();
        if (win) m1.cmd_valid = 1'b0; else m0.cmd_valid = 1'b0;
        dm.rsp_valid = 1'b1; dm.rsp_rdata = rdat;
        @(negedge clk);
        check({t, ".rsp_cvalid"}, dm.cmd_valid, 64'd0);
        check({t, ".win_rv"},     win ? m1.rsp_valid : m0.rsp_valid, 64'd1);
        check({t, ".win_rdata"},  win ? m1.rsp_rdata : m0.rsp_rdata, {32'd0, rdat});
        check({t, ".lose_rv"},    win ? m0.rsp_valid : m1.rsp_valid, 64'd0);
        check({t, ".lose_rdata"}, win ? m0.rsp_rdata : m1.rsp_rdata, 64'd0);
        check({t, ".rrdy"},       dm.rsp_ready, 64'd1);
        tick();
        dm.rsp_valid = 1'b0; m0.cmd_valid = 1'b0; m1.cmd_valid = 1'b0;
        @(negedge clk);
        check_idle({t, ".done"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m0.cmd_valid = 0; m0.cmd_addr = '0; m0.cmd_read = 0; m0.cmd_wdata = '0; m0.rsp_ready = 0;
        m1.cmd_valid = 0; m1.cmd_addr = '0; m1.cmd_read = 0; m1.cmd_wdata = '0; m1.rsp_ready = 0;
        dm.cmd_ready = 0; dm.rsp_valid = 0; dm.rsp_rdata = '0;
        #1 rst_n = 1'b0;
        #2;
        check_idle("rst");
        check("rst.addr",  dm.cmd_addr,  64'd0);
        check("rst.read",  dm.cmd_read,  64'd0);
        check("rst.wdata", dm.cmd_wdata, 64'd0);
        check("rst.rrdy",  dm.rsp_ready, 64'd0);
        check("rst.m0crdy", m0.cmd_ready, 64'd0);
        check("rst.m1crdy", m1.cmd_ready, 64'd0);
        check("rst.m0rd",  m0.rsp_rdata, 64'd0);
        check("rst.m1rd",  m1.rsp_rdata, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle10.grant", o_grant, 64'd0);
            check("idle10.busy",  o_busy,  64'd0);
        end

        // Single m0 read
        txn("m0rd", 1'b1, 1'b0, 1'b0, 12'h038, 1'b1, 32'h0, 32'hDEADBEEF);

        // m1 write with DM and m1 backpressure; m0 arrives while m1 owns the bus
        tick();
        m1.cmd_valid = 1; m1.cmd_addr = 12'h010; m1.cmd_read = 0; m1.cmd_wdata = 32'h12345678;
        m1.rsp_ready = 0; dm.cmd_ready = 0;
        @(negedge clk);
        check("bp.idle", o_grant, 64'd0);
        tick();
        m0.cmd_valid = 1; m0.cmd_addr = 12'h020; m0.cmd_read = 1; m0.rsp_ready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.grant", o_grant,      64'd2);
            check("bp.addr",  dm.cmd_addr,  64'h010);
            check("bp.wdata", dm.cmd_wdata, 64'h12345678);
            check("bp.read",  dm.cmd_read,  64'd0);
            check("bp.m1crdy", m1.cmd_ready, 64'd0);
            check("bp.m0crdy", m0.cmd_ready, 64'd0);
            tick();
        end
        dm.cmd_ready = 1;
        @(negedge clk);
        check("bp.m1crdy_acc", m1.cmd_ready, 64'd1);
        tick();
        m1.cmd_valid = 0; dm.rsp_valid = 1; dm.rsp_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp.rsp_grant", o_grant,      64'd2);
            check("bp.m1rv",      m1.rsp_valid, 64'd1);
            check("bp.rrdy",      dm.rsp_ready, 64'd0);
            check("bp.m0rv",      m0.rsp_valid, 64'd0);
            tick();
        end
        m1.rsp_ready = 1;
        @(negedge clk);
        check("bp.rrdy_go", dm.rsp_ready, 64'd1);
        tick();
        dm.rsp_valid = 0;
        @(negedge clk);
        check("bp.gap", o_grant, 64'd0);
        tick();
        @(negedge clk);
        check("bp.m0grant", o_grant,     64'd1);
        check("bp.m0addr",  dm.cmd_addr, 64'h020);
        tick();
        m0.cmd_valid = 0; dm.rsp_valid = 1; dm.rsp_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("bp.m0rdata", m0.rsp_rdata, 64'hCAFEF00D);
        tick();
        dm.rsp_valid = 0;

        // Reset while in RSP
        tick();
        m0.cmd_valid = 1; m0.cmd_addr = 12'h030; m0.cmd_read = 1; m0.rsp_ready = 0; dm.cmd_ready = 1;
        @(negedge clk);
        tick();
        tick();
        m0.cmd_valid = 0; dm.rsp_valid = 1; dm.rsp_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        check("rstrsp.busy_pre", o_busy,      64'd1);
        check("rstrsp.m0rv_pre", m0.rsp_valid, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstrsp.busy",  o_busy,       64'd0);
        check("rstrsp.grant", o_grant,      64'd0);
        check("rstrsp.m0rv",  m0.rsp_valid, 64'd0);
        check("rstrsp.m0rd",  m0.rsp_rdata, 64'd0);
        dm.rsp_valid = 0; m0.rsp_ready = 1;
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("rstrsp.post");
        txn("m1after", 1'b0, 1'b1, 1'b1, 12'h044, 1'b1, 32'h0, 32'h0BADF00D);

        // Simultaneous requests alternate m0, m1, m0, m1
        txn("rr0", 1'b1, 1'b1, 1'b0, 12'h004, 1'b1, 32'h11111111, 32'hA0A0A0A0);
        txn("rr1", 1'b1, 1'b1, 1'b1, 12'h008, 1'b0, 32'h22222222, 32'hB1B1B1B1);
        txn("rr2", 1'b1, 1'b1, 1'b0, 12'h00C, 1'b0, 32'h33333333, 32'hC2C2C2C2);
        txn("rr3", 1'b1, 1'b1, 1'b1, 12'h014, 1'b1, 32'h44444444, 32'hD3D3D3D3);

        // m0 withdraws in CMD: back to IDLE, rr_ptr keeps favouring m0
        tick();
        m0.cmd_valid = 1; m0.cmd_addr = 12'h050; dm.cmd_ready = 0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("drop.grant", o_grant, 64'd1);
        tick();
        m0.cmd_valid = 0;
        @(negedge clk);
        check("drop.cvalid", dm.cmd_valid, 64'd0);
        tick();
        @(negedge clk);
        check_idle("drop.idle");
        txn("drop.next", 1'b1, 1'b1, 1'b0, 12'h060, 1'b1, 32'h0, 32'h76543210);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
